// File: rtl/pkt_router_pkg.sv
// Shared types and helpers for the multicast packet router family.
// Route vectors are one bit per output channel; counters saturate instead of wrapping.
package pkt_router_pkg;

  localparam int KEY_BITS         = 32;
  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_CNT_BITS     = 16;

  typedef logic [KEY_BITS-1:0]         key_t;
  typedef logic [DEF_NUM_CHANNELS-1:0] route_t;
  typedef logic [DEF_CNT_BITS-1:0]     cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pkt_route_lookup.sv
// Ternary key/mask routing table lookup: first (lowest-index) matching entry supplies the route vector.
// Purely combinational; shared by router variants.
module pkt_route_lookup
  import pkt_router_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  key_t                     key_in,
  input  key_t   [NUM_ENTRIES-1:0] reg_key_in,
  input  key_t   [NUM_ENTRIES-1:0] reg_mask_in,
  input  route_t [NUM_ENTRIES-1:0] reg_route_in,
  output route_t                   route_out,
  output logic                     hit_any_out
);

  // Scan from the highest index down so the lowest matching entry is the last writer.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    route_out   = '0;
    hit_any_out = 1'b0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (reg_key_in[e] == (reg_mask_in[e] & key_in)) begin
        route_out   = reg_route_in[e];
        hit_any_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_router_mc.sv
// Registered multicast router: one holding register, a per-channel pending vector and saturating statistics.
// Define PKT_ROUTER_MC_TIMEOUT_EN to drop pending copies after TIMEOUT cycles without any channel handshake.
module pkt_router_mc
  import pkt_router_pkg::*;
#(
  parameter int PACKET_BITS  = 72,
  parameter int KEY_LSB      = 8,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int NUM_ENTRIES  = 16,
  parameter int CNT_BITS     = DEF_CNT_BITS,
  parameter int TIMEOUT      = 256
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  key_t   [NUM_ENTRIES-1:0]                  reg_key_in,
  input  key_t   [NUM_ENTRIES-1:0]                  reg_mask_in,
  input  route_t [NUM_ENTRIES-1:0]                  reg_route_in,
  input  logic   [PACKET_BITS-1:0]                  pkt_in_data_in,
  input  logic                                      pkt_in_vld_in,
  output logic                                      pkt_in_rdy_out,
  output logic   [NUM_CHANNELS-1:0][PACKET_BITS-1:0] pkt_out_data_out,
  output logic   [NUM_CHANNELS-1:0]                 pkt_out_vld_out,
  input  logic   [NUM_CHANNELS-1:0]                 pkt_out_rdy_in,
  output cnt_t                                      routed_cnt_out,
  output cnt_t                                      dropped_cnt_out
);

  route_t                 pending_q, pending_d;
  logic [PACKET_BITS-1:0] data_q, data_d;
  cnt_t                   routed_cnt_q, routed_cnt_d;
  cnt_t                   dropped_cnt_q, dropped_cnt_d;

  route_t lookup_route;
  logic   lookup_hit;
  route_t handshake;
  logic   accept;
  logic   timeout_fire;

  pkt_route_lookup #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_lookup (
    .key_in       (pkt_in_data_in[KEY_LSB +: KEY_BITS]),
    .reg_key_in   (reg_key_in),
    .reg_mask_in  (reg_mask_in),
    .reg_route_in (reg_route_in),
    .route_out    (lookup_route),
    .hit_any_out  (lookup_hit)
  );

  assign handshake = pending_q & pkt_out_rdy_in;
  // Ready whenever every outstanding copy is either absent or leaving this cycle.
  assign pkt_in_rdy_out = ((pending_q & ~pkt_out_rdy_in) == '0);
  assign accept         = pkt_in_vld_in & pkt_in_rdy_out;

`ifdef PKT_ROUTER_MC_TIMEOUT_EN
  localparam int STALL_BITS = $clog2(TIMEOUT + 1);

  logic [STALL_BITS-1:0] stall_q, stall_d;

  always_comb begin
    stall_d      = stall_q;
    timeout_fire = 1'b0;
    if (accept || (handshake != '0) || (pending_q == '0)) begin
      stall_d = '0;
    end else if (stall_q == STALL_BITS'(TIMEOUT - 1)) begin
      timeout_fire = 1'b1;
      stall_d      = '0;
    end else begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    pending_d     = pending_q & ~pkt_out_rdy_in;
    data_d        = data_q;
    routed_cnt_d  = routed_cnt_q;
    dropped_cnt_d = dropped_cnt_q;
    if (timeout_fire) begin
      pending_d     = '0;
      dropped_cnt_d = sat_inc(dropped_cnt_q);
    end
    // The table is sampled only here, so later table edits never reroute a pending packet.
    if (accept) begin
      data_d = pkt_in_data_in;
      if (lookup_hit && (lookup_route != '0)) begin
        pending_d    = lookup_route;
        routed_cnt_d = sat_inc(routed_cnt_q);
      end else begin
        pending_d     = '0;
        dropped_cnt_d = sat_inc(dropped_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the holding register is a single word, not a memory, so it is reset so idle outputs read zero.
      pending_q     <= '0;
      data_q        <= '0;
      routed_cnt_q  <= '0;
      dropped_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pending_q     <= pending_d;
      data_q        <= data_d;
      routed_cnt_q  <= routed_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) pkt_out_data_out[c] = data_q;
  end

  assign pkt_out_vld_out = pending_q;
  assign routed_cnt_out  = routed_cnt_q;
  assign dropped_cnt_out = dropped_cnt_q;

endmodule

// File: tb/tb_pkt_router_mc.sv
// Self-checking bench for pkt_router_mc: directed scenarios plus randomized traffic against a reference model.
// Honours PKT_ROUTER_MC_TIMEOUT_EN the same way as the design (TIMEOUT is set to 4 here).
module tb_pkt_router_mc;

  localparam int PB = 72;
  localparam int NC = 8;
  localparam int NE = 16;
  localparam int CB = 16;
  localparam int TO = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NE-1:0][31:0]    reg_key, reg_mask;
  logic [NE-1:0][NC-1:0]  reg_route;
  logic [PB-1:0]          in_data = '0;
  logic                   in_vld = 1'b0;
  logic                   in_rdy;
  logic [NC-1:0][PB-1:0]  out_data;
  logic [NC-1:0]          out_vld;
  logic [NC-1:0]          out_rdy = '1;
  logic [CB-1:0]          routed_cnt, dropped_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: which channels still owe a copy, the packet they owe, and the statistics.
  logic [NC-1:0] m_busy;
  logic [PB-1:0] m_data;
  logic [CB-1:0] m_routed, m_dropped;
`ifdef PKT_ROUTER_MC_TIMEOUT_EN
  int            m_stall;
`endif

  always #5 clk = ~clk;

  pkt_router_mc #(
    .PACKET_BITS (PB), .KEY_LSB (8), .NUM_CHANNELS (NC),
    .NUM_ENTRIES (NE), .CNT_BITS (CB), .TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .reg_key_in       (reg_key),
    .reg_mask_in      (reg_mask),
    .reg_route_in     (reg_route),
    .pkt_in_data_in   (in_data),
    .pkt_in_vld_in    (in_vld),
    .pkt_in_rdy_out   (in_rdy),
    .pkt_out_data_out (out_data),
    .pkt_out_vld_out  (out_vld),
    .pkt_out_rdy_in   (out_rdy),
    .routed_cnt_out   (routed_cnt),
    .dropped_cnt_out  (dropped_cnt)
  );

  function automatic logic [PB-1:0] mk_pkt(input logic [31:0] key);
    logic [31:0] hi = $urandom;
    logic [7:0]  lo = 8'($urandom);
    return {hi, key, lo};
  endfunction

  function automatic logic [31:0] rand_key();
    return {4'($urandom), 24'h0, 4'($urandom)};
  endfunction

  function automatic logic [CB-1:0] sat(input logic [CB-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // First entry (in index order) whose masked key equals the stored key decides; otherwise nothing.
  function automatic logic [NC-1:0] ref_route(input logic [31:0] key);
    for (int e = 0; e < NE; e++)
      if ((key & reg_mask[e]) == reg_key[e]) return reg_route[e];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    out_rdy = '1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_busy = '0; m_data = '0; m_routed = '0; m_dropped = '0;
`ifdef PKT_ROUTER_MC_TIMEOUT_EN
    m_stall = 0;
`endif
  endtask

  task automatic clear_table();
    for (int e = 0; e < NE; e++) begin
      reg_key[e] = 32'hFFFF_FFFF; reg_mask[e] = 32'h0; reg_route[e] = '0;
    end
  endtask

  task automatic randomize_table();
    logic [31:0] m;
    for (int e = 0; e < NE; e++) begin
      case ($urandom_range(0, 19))
        0:             m = 32'h0000_0000;
        1, 2, 3, 4, 5: m = 32'hF000_000F;
        6, 7, 8, 9:    m = 32'h0000_000F;
        10, 11, 12:    m = 32'hF000_0000;
        default:       m = 32'hFFFF_FFFF;
      endcase
      reg_mask[e]  = m;
      reg_key[e]   = rand_key() & m;
      reg_route[e] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    end
  endtask

  // Advance the model across the coming clock edge using the inputs currently applied.
  task automatic model_step();
    logic [NC-1:0] hs, route;
    logic acc, fire;
    hs   = m_busy & out_rdy;
    acc  = in_vld && ((m_busy & ~out_rdy) == '0);
    fire = 1'b0;
`ifdef PKT_ROUTER_MC_TIMEOUT_EN
    if ((m_busy != '0) && (hs == '0) && !acc) begin
      if (m_stall == TO - 1) begin fire = 1'b1; m_stall = 0; end
      else m_stall++;
    end else begin
      m_stall = 0;
    end
`endif
    m_busy = m_busy & ~hs;
    if (fire) begin m_busy = '0; m_dropped = sat(m_dropped); end
    if (acc) begin
      route  = ref_route(in_data[8 +: 32]);
      m_data = in_data;
      m_busy = route;
      if (route != '0) m_routed = sat(m_routed);
      else             m_dropped = sat(m_dropped);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL reset_vld: got %h expected 00", out_vld); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", in_rdy); end
    n_cmp++; if (routed_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_routed: got %h expected 0000", routed_cnt); end
    n_cmp++; if (dropped_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_dropped: got %h expected 0000", dropped_cnt); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
  endtask

  task automatic test_unicast_drop();
    logic [PB-1:0] p1, p2;
    do_reset(); clear_table();
    reg_key[0] = 32'h0000_0100; reg_mask[0] = 32'hFFFF_FF00; reg_route[0] = 8'h05;
    p1 = mk_pkt(32'h1234_0142); p2 = mk_pkt(32'h0000_0142);
    in_data = p1; in_vld = 1'b1; tick();
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL drop_vld: got %h expected 00", out_vld); end
    n_cmp++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt: got %0d expected 1", dropped_cnt); end
    in_data = p2; tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h05) begin n_fail++; $display("FAIL uni_vld: got %h expected 05", out_vld); end
    n_cmp++; if (out_data[0] !== p2) begin n_fail++; $display("FAIL uni_data0: got %h expected %h", out_data[0], p2); end
    n_cmp++; if (out_data[2] !== p2) begin n_fail++; $display("FAIL uni_data2: got %h expected %h", out_data[2], p2); end
    n_cmp++; if (routed_cnt !== 16'd1) begin n_fail++; $display("FAIL uni_routed: got %0d expected 1", routed_cnt); end
    tick();
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL uni_drain: got %h expected 00", out_vld); end
  endtask

  task automatic test_multicast_stall();
    logic [PB-1:0] pa, pb;
    logic [NC-1:0] exp_vld;
    do_reset(); clear_table();
    reg_key[0] = 32'h0000_0100; reg_mask[0] = 32'hFFFF_FF00; reg_route[0] = 8'h05;
    pa = mk_pkt(32'h0000_0142); pb = mk_pkt(32'h0000_01FF);
    out_rdy = 8'h01; in_data = pa; in_vld = 1'b1; tick();
    in_data = pb;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_vld = (i == 0) ? 8'h05 : 8'h04;
      n_cmp++; if (out_vld !== exp_vld) begin n_fail++; $display("FAIL mc_vld[%0d]: got %h expected %h", i, out_vld, exp_vld); end
      n_cmp++; if (out_data[2] !== pa) begin n_fail++; $display("FAIL mc_data2[%0d]: got %h expected %h", i, out_data[2], pa); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL mc_rdy[%0d]: got %b expected 0", i, in_rdy); end
      tick();
    end
    out_rdy = '1; #1;
    n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mc_release_rdy: got %b expected 1", in_rdy); end
    tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h05) begin n_fail++; $display("FAIL mc_b2b_vld: got %h expected 05", out_vld); end
    n_cmp++; if (out_data[0] !== pb) begin n_fail++; $display("FAIL mc_b2b_data: got %h expected %h", out_data[0], pb); end
    n_cmp++; if (routed_cnt !== 16'd2) begin n_fail++; $display("FAIL mc_routed: got %0d expected 2", routed_cnt); end
`ifdef PKT_ROUTER_MC_TIMEOUT_EN
    n_cmp++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL mc_dropped: got %0d expected 1", dropped_cnt); end
`else
    n_cmp++; if (dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL mc_dropped: got %0d expected 0", dropped_cnt); end
`endif
  endtask

  task automatic test_priority();
    logic [PB-1:0] p;
    do_reset(); clear_table();
    reg_key[3] = 32'h0; reg_mask[3] = 32'h0; reg_route[3] = 8'h08;
    reg_key[7] = 32'h0; reg_mask[7] = 32'h0; reg_route[7] = 8'h80;
    p = mk_pkt($urandom); in_data = p; in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h08) begin n_fail++; $display("FAIL prio_vld: got %h expected 08", out_vld); end
    n_cmp++; if (out_data[3] !== p) begin n_fail++; $display("FAIL prio_data: got %h expected %h", out_data[3], p); end
    tick();
    reg_key[1] = 32'hCAFE_0000; reg_mask[1] = 32'hFFFF_0000; reg_route[1] = 8'h00;
    in_data = mk_pkt(32'hCAFE_1234); in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL zero_route_vld: got %h expected 00", out_vld); end
    n_cmp++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL zero_route_drop: got %0d expected 1", dropped_cnt); end
  endtask

  task automatic test_stream_saturate();
    logic [PB-1:0] p;
    do_reset(); clear_table();
    reg_key[0] = 32'h0; reg_mask[0] = 32'h0; reg_route[0] = 8'h01;
    for (int i = 0; i < 10; i++) begin
      p = mk_pkt($urandom); in_data = p; in_vld = 1'b1; #1;
      n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_rdy[%0d]: got %b expected 1", i, in_rdy); end
      tick();
      n_cmp++; if (out_vld !== 8'h01) begin n_fail++; $display("FAIL stream_vld[%0d]: got %h expected 01", i, out_vld); end
      n_cmp++; if (out_data[0] !== p) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data[0], p); end
    end
    in_vld = 1'b0; tick();
    n_cmp++; if (routed_cnt !== 16'd10) begin n_fail++; $display("FAIL stream_routed: got %0d expected 10", routed_cnt); end
    force dut.routed_cnt_q = 16'hFFFF;
    #1;
    release dut.routed_cnt_q;
    #1;
    in_data = mk_pkt($urandom); in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_cmp++; if (routed_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_routed: got %h expected ffff", routed_cnt); end
    n_cmp++; if (out_vld !== 8'h01) begin n_fail++; $display("FAIL sat_vld: got %h expected 01", out_vld); end
  endtask

  task automatic test_reset_midway();
    do_reset(); clear_table();
    reg_key[0] = 32'h0; reg_mask[0] = 32'h0; reg_route[0] = 8'h05;
    out_rdy = '0; in_data = mk_pkt($urandom); in_vld = 1'b1; tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h05) begin n_fail++; $display("FAIL mid_pending: got %h expected 05", out_vld); end
    reset = 1'b1; #1;
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL mid_vld: got %h expected 00", out_vld); end
    n_cmp++; if (routed_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_routed: got %0d expected 0", routed_cnt); end
    n_cmp++; if (dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_dropped: got %0d expected 0", dropped_cnt); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy: got %b expected 1", in_rdy); end
    @(negedge clk); reset = 1'b0; out_rdy = '1; tick();
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL mid_after_vld: got %h expected 00", out_vld); end
  endtask

  task automatic test_timeout();
    logic [PB-1:0] p;
    do_reset(); clear_table();
    reg_key[0] = 32'h0; reg_mask[0] = 32'h0; reg_route[0] = 8'h02;
    p = mk_pkt($urandom); out_rdy = 8'hFD; in_data = p; in_vld = 1'b1; tick(); in_vld = 1'b0;
`ifdef PKT_ROUTER_MC_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      n_cmp++; if (out_vld !== 8'h02) begin n_fail++; $display("FAIL to_vld[%0d]: got %h expected 02", i, out_vld); end
      tick();
    end
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL to_cleared: got %h expected 00", out_vld); end
    n_cmp++; if (dropped_cnt !== 16'd1) begin n_fail++; $display("FAIL to_dropped: got %0d expected 1", dropped_cnt); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL to_rdy: got %b expected 1", in_rdy); end
    p = mk_pkt($urandom); in_data = p; in_vld = 1'b1; out_rdy = '1; tick(); in_vld = 1'b0;
    n_cmp++; if (out_vld !== 8'h02) begin n_fail++; $display("FAIL to_next_vld: got %h expected 02", out_vld); end
    n_cmp++; if (out_data[1] !== p) begin n_fail++; $display("FAIL to_next_data: got %h expected %h", out_data[1], p); end
`else
    for (int i = 0; i < 100; i++) begin
      n_cmp++; if (out_vld !== 8'h02) begin n_fail++; $display("FAIL hold_vld[%0d]: got %h expected 02", i, out_vld); end
      n_cmp++; if (out_data[1] !== p) begin n_fail++; $display("FAIL hold_data[%0d]: got %h expected %h", i, out_data[1], p); end
      tick();
    end
    n_cmp++; if (dropped_cnt !== 16'd0) begin n_fail++; $display("FAIL hold_dropped: got %0d expected 0", dropped_cnt); end
    out_rdy = '1; tick();
    n_cmp++; if (out_vld !== 8'h00) begin n_fail++; $display("FAIL hold_drain: got %h expected 00", out_vld); end
`endif
  endtask

  task automatic test_random();
    logic exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 50 == 0) randomize_table();
      in_vld  = ($urandom_range(0, 9) < 7);
      in_data = mk_pkt(rand_key());
      out_rdy = 8'($urandom) | 8'($urandom);
      #1;
      exp_rdy = ((m_busy & ~out_rdy) == '0);
      n_cmp++; if (out_vld !== m_busy) begin n_fail++; $display("FAIL rnd_vld@%0d: got %h expected %h", cyc, out_vld, m_busy); end
      n_cmp++; if (in_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy@%0d: got %b expected %b", cyc, in_rdy, exp_rdy); end
      n_cmp++; if (routed_cnt !== m_routed) begin n_fail++; $display("FAIL rnd_routed@%0d: got %0d expected %0d", cyc, routed_cnt, m_routed); end
      n_cmp++; if (dropped_cnt !== m_dropped) begin n_fail++; $display("FAIL rnd_dropped@%0d: got %0d expected %0d", cyc, dropped_cnt, m_dropped); end
      for (int c = 0; c < NC; c++) begin
        if (m_busy[c]) begin
          n_cmp++; if (out_data[c] !== m_data) begin n_fail++; $display("FAIL rnd_data%0d@%0d: got %h expected %h", c, cyc, out_data[c], m_data); end
        end
      end
      model_step();
      tick();
    end
    in_vld = 1'b0;
  endtask

  initial begin
    clear_table();
    test_reset();
    test_unicast_drop();
    test_multicast_stall();
    test_priority();
    test_stream_saturate();
    test_reset_midway();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
